dircc_heat_cell: RTL and testbench
==================================

# dircc_heat_cell

Hardware device handler for the heat-diffusion application. One instance implements one graph device. It consumes `temp_msg_t`-format messages arriving on the device's single input port and keeps the per-device state (`t`, `heat`, `accNow`/`seenNow`, `accNext`/`seenNext`). Each time all neighbours have reported for the current step, it computes the relaxed temperature and emits one message on output port 0, which feeds the fan-out sender that walks the port's target list.

## Interface

Parameters:
- `NEIGHBOUR_COUNT`, default 4: expected messages per step. Legal range 1..7, matching the 3-bit seen counters.
- `SELF_WEIGHT`, default 8'd52: self weight in the kernel, unsigned Q0.8.
- `INIT_VALUE`, default 0: heat at reset, 15 bits.
- `IS_DIRICHLET`, default 0: when 1, heat is held at `INIT_VALUE` forever.
- `MAX_TIME`, default 3: last step emitted, 13 bits.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input message present.
- `in_ready`  out  1  block accepts input this cycle.
- `in_t`  in  13  sender's time step.
- `in_temp`  in  15  sender's heat, unsigned.
- `in_weight`  in  8  edge weight, Q0.8, from the source binding.
- `out_valid`  out  1  output message present.
- `out_ready`  in  1  fan-out stage accepts.
- `out_t`  out  13  this device's time step.
- `out_temp`  out  15  this device's heat.
- `done`  out  1  step `MAX_TIME` has been sent; sticky.
- `err`  out  1  sticky; an input arrived with `t` outside {cur, cur+1}.

## Operation

- **State registers:** `t[12:0]`, `heat[14:0]`, `accNow[25:0]`, `seenNow[2:0]`, `accNext[25:0]`, `seenNext[2:0]`.
- **FSM states:** SEND, RECV, COMPUTE, DONE. Reset state is SEND with `t=0` and `heat=INIT_VALUE`, so step 0 is announced first.
- **SEND:**
  - `out_valid=1`, `out_t=t`, `out_temp=heat`; `in_ready=0`.
  - On `out_valid&out_ready`:
    - if `t==MAX_TIME`, go to DONE;
    - else if `seenNow==NEIGHBOUR_COUNT`, go to COMPUTE;
    - else go to RECV.
- **RECV:**
  - `in_ready=1`. On handshake, with product `p = in_temp*in_weight` (23 bits, zero-extended to 26):
    - `in_t==t`: `accNow+=p`, `seenNow++`.
    - `in_t==t+1`: `accNext+=p`, `seenNext++`.
    - Otherwise: message dropped, `err<=1`.
  - Move to COMPUTE in the cycle after the handshake that makes `seenNow==NEIGHBOUR_COUNT`.
- **COMPUTE** (1 cycle):
  - `sum = accNow + SELF_WEIGHT*heat`, 26 bits.
  - `heat <= IS_DIRICHLET ? INIT_VALUE : sat15(sum>>8)`, where `sat15` clamps to 32767.
  - `t <= t+1`.
  - `accNow <= accNext`, `seenNow <= seenNext`, `accNext <= 0`, `seenNext <= 0`.
  - Go to SEND.
- **DONE:**
  - `done=1`, `in_ready=1`.
  - Accepted inputs are discarded with no `err` and no state change.
- **Width rules:** the `t+1` compare is 13-bit modulo. `MAX_TIME < 8191` is guaranteed by the generator, so no wrap occurs.

## Timing

- **Reset values:**
  - `out_valid`=1, `out_t`=0, `out_temp`=`INIT_VALUE`.
  - `in_ready`=0, `done`=0, `err`=0.
  - All accumulators and counters are 0.
- **Latency:** from the completing input handshake (cycle N), state is COMPUTE at N+1 and `out_valid=1` with the new step at N+2.
- **Output handshake:** `out_*` is held stable while `out_valid&!out_ready`. There is no combinational path from `out_ready` to `out_*`.
- **Back-pressure on input:** `in_ready` is a registered state decode. It is 0 in SEND and COMPUTE, so inputs are never accepted in the same cycle as a step change.
- **Back-to-back steps:** if `seenNext` already equals `NEIGHBOUR_COUNT` at COMPUTE, the next SEND goes straight to COMPUTE with no RECV cycle.
- **Reset mid-operation:** asserting `reset_n=0` at any point returns every register to its reset value immediately. Any in-flight message is lost.

## Test plan

- **Reset announce:** release reset with `INIT_VALUE=0` and `out_ready=1` -> first output is `t=0`, `temp=0`; then `in_ready=1`.
- **Relaxation:** defaults (N=4, self 52). Send four messages `t=0`, `temp=10000`, `weight=51` -> exactly 2 cycles after the 4th handshake, output `t=1`, `temp=7968`.
- **Early next-step messages:** interleave two `t=1` messages before the last `t=0` message -> step 1 output appears on time, and the step 2 result uses `accNext` correctly, checked against the model.
- **Dirichlet:** `IS_DIRICHLET=1`, `INIT_VALUE=10`, N=1 -> outputs `t=0..3`, all `temp=10`; `done=1` after the `t=3` handshake; a later input is accepted with `err=0`.
- **Saturation and error:** N=4, all `weight=255`, `temp=32767` -> `out_temp=32767`. Then send `in_t=5` while `t=1` -> `err=1`, and the message does not affect the counters.
- **Back-pressure and reset:** hold `out_ready=0` for 10 cycles -> `out_*` stable and `in_ready=0`. Assert `reset_n=0` mid-RECV -> next output is `t=0`, `temp=INIT_VALUE`.

Source files
------------

// File: rtl/dircc_heat_cell.sv
// One heat-diffusion graph device: collects neighbour heat reports for each time step,
// relaxes its own temperature with a fixed-point kernel, and announces every step.
module dircc_heat_cell #(
  parameter int unsigned NEIGHBOUR_COUNT = 4,
  parameter logic [7:0]  SELF_WEIGHT     = 8'd52,
  parameter logic [14:0] INIT_VALUE      = 15'd0,
  parameter bit          IS_DIRICHLET    = 1'b0,
  parameter logic [12:0] MAX_TIME        = 13'd3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] in_t,
  input  logic [14:0] in_temp,
  input  logic [7:0]  in_weight,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] out_t,
  output logic [14:0] out_temp,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_SEND    = 2'd0,
    ST_RECV    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [2:0] NEIGHBOURS_C = 3'(NEIGHBOUR_COUNT);

  // (sum >> 8) clamped to the 15-bit heat range
  function automatic logic [14:0] sat15(input logic [25:0] v);
    logic [14:0] r;
    if (v[25:23] != 3'b000) begin
      r = 15'h7FFF;
    end else begin
      r = v[22:8];
    end
    return r;
  endfunction

  state_t      state_r;
  logic [12:0] t_r;
  logic [14:0] heat_r;
  logic [25:0] acc_now_r;
  logic [2:0]  seen_now_r;
  logic [25:0] acc_next_r;
  logic [2:0]  seen_next_r;
  logic        out_valid_r;
  logic        in_ready_r;
  logic        done_r;
  logic        err_r;
  logic [12:0] out_t_r;
  logic [14:0] out_temp_r;

  logic [22:0] prod23_s;
  logic [25:0] prod_s;
  logic [22:0] self_term_s;
  logic [25:0] sum_s;
  logic [14:0] new_heat_s;
  logic [12:0] t_plus1_s;
  logic [2:0]  seen_now_inc_s;
  logic        in_hs_s;

  assign prod23_s       = in_temp * in_weight;
  assign prod_s         = {3'b000, prod23_s};
  assign self_term_s    = SELF_WEIGHT * heat_r;
  assign sum_s          = acc_now_r + {3'b000, self_term_s};
  assign new_heat_s     = IS_DIRICHLET ? INIT_VALUE : sat15(sum_s);
  assign t_plus1_s      = t_r + 13'd1;
  assign seen_now_inc_s = seen_now_r + 3'd1;
  assign in_hs_s        = in_valid & in_ready_r;

  // Device FSM: state registers and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_SEND;
      t_r         <= 13'd0;
      heat_r      <= INIT_VALUE;
      acc_now_r   <= 26'd0;
      seen_now_r  <= 3'd0;
      acc_next_r  <= 26'd0;
      seen_next_r <= 3'd0;
      out_valid_r <= 1'b1;
      in_ready_r  <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      out_t_r     <= 13'd0;
      out_temp_r  <= INIT_VALUE;
    end else begin
      case (state_r)
        ST_SEND: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (t_r == MAX_TIME) begin
              state_r    <= ST_DONE;
              done_r     <= 1'b1;
              in_ready_r <= 1'b1;
            end else if (seen_now_r == NEIGHBOURS_C) begin
              // every neighbour already reported early: skip RECV
              state_r <= ST_COMPUTE;
            end else begin
              state_r    <= ST_RECV;
              in_ready_r <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (in_hs_s) begin
            if (in_t == t_r) begin
              acc_now_r  <= acc_now_r + prod_s;
              seen_now_r <= seen_now_inc_s;
              if (seen_now_inc_s == NEIGHBOURS_C) begin
                state_r    <= ST_COMPUTE;
                in_ready_r <= 1'b0;
              end
            end else if (in_t == t_plus1_s) begin
              acc_next_r  <= acc_next_r + prod_s;
              seen_next_r <= seen_next_r + 3'd1;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          heat_r      <= new_heat_s;
          t_r         <= t_plus1_s;
          acc_now_r   <= acc_next_r;
          seen_now_r  <= seen_next_r;
          acc_next_r  <= 26'd0;
          seen_next_r <= 3'd0;
          out_valid_r <= 1'b1;
          out_t_r     <= t_plus1_s;
          out_temp_r  <= new_heat_s;
          state_r     <= ST_SEND;
        end
        ST_DONE: begin
          // late inputs are swallowed silently
          in_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_SEND;
          out_valid_r <= 1'b1;
          in_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_t     = out_t_r;
  assign out_temp  = out_temp_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_dircc_heat_cell.sv
// Self-checking bench for dircc_heat_cell: step table plus directed corner sequences,
// with every output message checked through a scoreboard queue.
module tb_dircc_heat_cell;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, done, err;
  logic [12:0] in_t, out_t;
  logic [14:0] in_temp, out_temp;
  logic [7:0]  in_weight;
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_done, d_err;
  logic [12:0] d_in_t, d_out_t;
  logic [14:0] d_in_temp, d_out_temp;
  logic [7:0]  d_in_weight;

  dircc_heat_cell u_dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_t(in_t), .in_temp(in_temp), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_t(out_t), .out_temp(out_temp),
    .done(done), .err(err)
  );

  dircc_heat_cell #(.NEIGHBOUR_COUNT(1), .INIT_VALUE(15'd10), .IS_DIRICHLET(1'b1)) u_dir (
    .clk(clk), .reset_n(reset_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_t(d_in_t), .in_temp(d_in_temp), .in_weight(d_in_weight),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_t(d_out_t), .out_temp(d_out_temp),
    .done(d_done), .err(d_err)
  );

  typedef struct { logic [12:0] t; logic [14:0] temp; } out_rec_t;
  typedef struct { logic [14:0] temp; logic [7:0] w; int exp_temp; } step_vec_t;

  out_rec_t  exp_q[$];
  out_rec_t  dexp_q[$];
  out_rec_t  mon_e, dmon_e;
  step_vec_t vec[3];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // integer-arithmetic reference of the relaxation kernel (self weight 52)
  function automatic int model(input int acc, input int heat);
    int q;
    q = (acc + 52 * heat) / 256;
    if (q > 32767) q = 32767;
    return q;
  endfunction

  task automatic push_exp(input bit dir, input int t, input int temp);
    out_rec_t r;
    r.t = 13'(t);
    r.temp = 15'(temp);
    if (dir) dexp_q.push_back(r);
    else exp_q.push_back(r);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit dir, input int t, input int temp, input int w);
    bit got;
    got = 1'b0;
    if (dir) begin
      d_in_valid = 1'b1; d_in_t = 13'(t); d_in_temp = 15'(temp); d_in_weight = 8'(w);
    end else begin
      in_valid = 1'b1; in_t = 13'(t); in_temp = 15'(temp); in_weight = 8'(w);
    end
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (dir ? d_in_ready : in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (dir) d_in_valid = 1'b0;
    else in_valid = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got no in_ready, expected handshake (dir=%0d t=%0d)", dir, t);
    end
  endtask

  task automatic drain(input bit dir);
    int k;
    k = 0;
    while ((dir ? dexp_q.size() : exp_q.size()) != 0 && k < 40) begin
      tick(1);
      k++;
    end
    if ((dir ? dexp_q.size() : exp_q.size()) != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending outputs, expected 0 (dir=%0d)",
               dir ? dexp_q.size() : exp_q.size(), dir);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; d_in_valid = 1'b0;
    out_ready = 1'b0; d_out_ready = 1'b0;
    tick(2);
    exp_q.delete();
    dexp_q.delete();
    reset_n = 1'b1;
  endtask

  // Scoreboard for the default device: handshake seen at negedge completes at next posedge
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL out_unexpected: got t=%0d temp=%0d, expected no output", out_t, out_temp);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_t", 32'(out_t), 32'(mon_e.t));
        check("out_temp", 32'(out_temp), 32'(mon_e.temp));
      end
    end
  end

  // Scoreboard for the Dirichlet device
  always @(negedge clk) begin
    if (reset_n && d_out_valid && d_out_ready) begin
      if (dexp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dir_out_unexpected: got t=%0d temp=%0d, expected no output", d_out_t, d_out_temp);
      end else begin
        dmon_e = dexp_q.pop_front();
        check("dir_out_t", 32'(d_out_t), 32'(dmon_e.t));
        check("dir_out_temp", 32'(d_out_temp), 32'(dmon_e.temp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected end of test");
    $fatal(1, "global timeout");
  end

  initial begin
    int h1, h2, h3;
    vec[0] = '{15'd10000, 8'd51, 7968};
    vec[1] = '{15'd20000, 8'd51, 17556};
    vec[2] = '{15'd0,     8'd0,  3566};
    in_t = 13'd0; in_temp = 15'd0; in_weight = 8'd0;
    d_in_t = 13'd0; d_in_temp = 15'd0; d_in_weight = 8'd0;

    // reset values
    do_reset();
    check("rst_out_valid", 32'(out_valid), 1);
    check("rst_out_t", 32'(out_t), 0);
    check("rst_out_temp", 32'(out_temp), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_dir_out_temp", 32'(d_out_temp), 10);

    // Dirichlet: heat pinned at 10 for every step
    d_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(1'b1, i, 10);
    for (int i = 0; i < 3; i++) send(1'b1, i, 5000, 200);
    drain(1'b1);
    tick(1);
    check("dir_done", 32'(d_done), 1);
    send(1'b1, 7, 123, 45);
    check("dir_late_err", 32'(d_err), 0);
    check("dir_late_done", 32'(d_done), 1);

    // table-driven relaxation steps with latency check on each completing handshake
    do_reset();
    out_ready = 1'b1;
    push_exp(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, i + 1, vec[i].exp_temp);
      for (int j = 0; j < 4; j++) send(1'b0, i, vec[i].temp, vec[i].w);
      check("lat_n1_valid", 32'(out_valid), 0);
      tick(1);
      check("lat_n2_valid", 32'(out_valid), 1);
      check("lat_n2_t", 32'(out_t), i + 1);
    end
    drain(1'b0);
    tick(1);
    check("done_set", 32'(done), 1);
    check("done_in_ready", 32'(in_ready), 1);
    send(1'b0, 100, 1, 1);
    check("done_no_err", 32'(err), 0);

    // early next-step messages, then back-to-back step from accNext
    do_reset();
    out_ready = 1'b1;
    h1 = model(4 * 10000 * 51, 0);
    push_exp(1'b0, 0, 0);
    push_exp(1'b0, 1, h1);
    for (int j = 0; j < 3; j++) send(1'b0, 0, 10000, 51);
    send(1'b0, 1, 4000, 100);
    send(1'b0, 1, 4000, 100);
    send(1'b0, 0, 10000, 51);
    tick(1);
    check("early_step1_valid", 32'(out_valid), 1);
    check("early_step1_t", 32'(out_t), 1);
    h2 = model(4 * 4000 * 100, h1);
    h3 = model(4 * 2000 * 64, h2);
    push_exp(1'b0, 2, h2);
    push_exp(1'b0, 3, h3);
    send(1'b0, 1, 4000, 100);
    for (int j = 0; j < 4; j++) send(1'b0, 2, 2000, 64);
    send(1'b0, 1, 4000, 100);
    drain(1'b0);
    tick(1);
    check("b2b_done", 32'(done), 1);
    check("b2b_err", 32'(err), 0);

    // saturation, then out-of-window messages must not count
    do_reset();
    out_ready = 1'b1;
    push_exp(1'b0, 0, 0);
    push_exp(1'b0, 1, 32767);
    for (int j = 0; j < 4; j++) send(1'b0, 0, 32767, 255);
    push_exp(1'b0, 2, model(0, 32767));
    send(1'b0, 5, 1000, 100);
    check("err_future", 32'(err), 1);
    send(1'b0, 0, 1000, 100);
    for (int j = 0; j < 3; j++) send(1'b0, 1, 0, 0);
    tick(3);
    check("err_no_count_valid", 32'(out_valid), 0);
    check("err_no_count_ready", 32'(in_ready), 1);
    send(1'b0, 1, 0, 0);
    drain(1'b0);
    check("err_sticky", 32'(err), 1);

    // back-pressure hold, then reset in the middle of RECV
    do_reset();
    out_ready = 1'b1;
    push_exp(1'b0, 0, 0);
    push_exp(1'b0, 1, 7968);
    for (int j = 0; j < 3; j++) send(1'b0, 0, 10000, 51);
    out_ready = 1'b0;
    send(1'b0, 0, 10000, 51);
    tick(1);
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", 32'(out_valid), 1);
      check("bp_t", 32'(out_t), 1);
      check("bp_temp", 32'(out_temp), 7968);
      check("bp_in_ready", 32'(in_ready), 0);
      tick(1);
    end
    out_ready = 1'b1;
    send(1'b0, 1, 5000, 10);
    send(1'b0, 1, 5000, 10);
    drain(1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 1);
    check("mid_rst_t", 32'(out_t), 0);
    check("mid_rst_temp", 32'(out_temp), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    tick(2);
    reset_n = 1'b1;
    push_exp(1'b0, 0, 0);
    push_exp(1'b0, 1, 7968);
    for (int j = 0; j < 4; j++) send(1'b0, 0, 10000, 51);
    drain(1'b0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
